// File: rtl/cia_pkg.sv
// Shared definitions for the CIA-style interval timer: register offsets,
// control/interrupt register bit positions and default widths.
package cia_pkg;

    localparam int TW_DEF = 16;
    localparam int DW_DEF = 8;

    localparam logic [3:0] OFF_TALO = 4'h4;
    localparam logic [3:0] OFF_TAHI = 4'h5;
    localparam logic [3:0] OFF_TBLO = 4'h6;
    localparam logic [3:0] OFF_TBHI = 4'h7;
    localparam logic [3:0] OFF_ICR  = 4'hD;
    localparam logic [3:0] OFF_CRA  = 4'hE;
    localparam logic [3:0] OFF_CRB  = 4'hF;

    localparam int CR_START   = 0;
    localparam int CR_ONESHOT = 3;
    localparam int CR_LOAD    = 4;
    localparam int CR_INMODE  = 5;  // two bits: [6:5]

    localparam int ICR_TA  = 0;
    localparam int ICR_TB  = 1;
    localparam int ICR_IRQ = 7;  // read: interrupt pending
    localparam int ICR_SET = 7;  // write: 1 = set mask bits, 0 = clear them

    typedef enum logic [1:0] {
        SRC_TICK  = 2'b00,
        SRC_OFF1  = 2'b01,
        SRC_TA_UF = 2'b10,
        SRC_OFF3  = 2'b11
    } src_e;

endpackage

// File: rtl/cia_timer_unit.sv
// One latch/down-counter pair with its control register (START/ONESHOT/LOAD).
// Underflow is combinational so a cascaded timer can count it in the same cycle.
module cia_timer_unit
    import cia_pkg::*;
#(
    parameter int TW = TW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          count_event,
    input  logic          lo_wr,
    input  logic          hi_wr,
    input  logic          cr_wr,
    input  logic [DW-1:0] di,
    output logic [TW-1:0] counter,
    output logic [DW-1:0] cr,
    output logic          underflow,
    output logic          start
);

    logic [TW-1:0] latch;
    logic [DW-1:0] cr_wdat;
    logic          load_strobe;

    always_comb begin
        cr_wdat          = di;
        cr_wdat[CR_LOAD] = 1'b0;
        load_strobe      = cr_wr && di[CR_LOAD];
        underflow        = count_event && (counter == '0);
        start            = cr[CR_START];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            latch <= '1;
        end else if (lo_wr) begin
            latch[DW-1:0] <= di;
        end else if (hi_wr) begin
            latch[TW-1:DW] <= di[TW-DW-1:0];
        end
    end

    // LOAD strobe wins over both reload and decrement; a stopped timer
    // also takes the high-byte write straight into the counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            counter <= '1;
        end else if (load_strobe) begin
            counter <= latch;
        end else if (hi_wr && !cr[CR_START]) begin
            counter <= {di[TW-DW-1:0], latch[DW-1:0]};
        end else if (underflow) begin
            counter <= latch;
        end else if (count_event) begin
            counter <= counter - TW'(1);
        end
    end

    // A software write in the same cycle as a one-shot stop takes precedence.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cr <= '0;
        end else if (cr_wr) begin
            cr <= cr_wdat;
        end else if (underflow && cr[CR_ONESHOT]) begin
            cr[CR_START] <= 1'b0;
        end
    end

endmodule

// File: rtl/cia_timer.sv
// Memory-mapped dual interval timer with CIA-style interrupt control.
// Reads return data one clock after the access; irq_n is registered.
module cia_timer
    import cia_pkg::*;
#(
    parameter int TW = TW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cs,
    input  logic          we,
    input  logic [3:0]    addr,
    input  logic [DW-1:0] di,
    output logic [DW-1:0] rd_data,
    input  logic          tick,
    output logic          irq_n
);

    logic          wr_hit, rd_hit;
    logic          count_a, count_b, src_b;
    logic          uf_a, uf_b, start_a, start_b;
    logic [TW-1:0] counter_a, counter_b;
    logic [DW-1:0] cr_a, cr_b;
    logic [1:0]    flags, flags_next;
    logic [1:0]    mask, mask_next;
    logic [DW-1:0] rd_mux;

    assign wr_hit = cs && we;
    assign rd_hit = cs && !we;

    always_comb begin
        src_b = 1'b0;
        case (cr_b[CR_INMODE+1:CR_INMODE])
            SRC_TICK:  src_b = tick;
            SRC_TA_UF: src_b = uf_a;
            default:   src_b = 1'b0;
        endcase
        count_a = start_a && tick;
        count_b = start_b && src_b;
    end

    cia_timer_unit #(.TW(TW), .DW(DW)) u_ta (
        .clk         (clk),
        .reset_n     (reset_n),
        .count_event (count_a),
        .lo_wr       (wr_hit && addr == OFF_TALO),
        .hi_wr       (wr_hit && addr == OFF_TAHI),
        .cr_wr       (wr_hit && addr == OFF_CRA),
        .di          (di),
        .counter     (counter_a),
        .cr          (cr_a),
        .underflow   (uf_a),
        .start       (start_a)
    );

    cia_timer_unit #(.TW(TW), .DW(DW)) u_tb (
        .clk         (clk),
        .reset_n     (reset_n),
        .count_event (count_b),
        .lo_wr       (wr_hit && addr == OFF_TBLO),
        .hi_wr       (wr_hit && addr == OFF_TBHI),
        .cr_wr       (wr_hit && addr == OFF_CRB),
        .di          (di),
        .counter     (counter_b),
        .cr          (cr_b),
        .underflow   (uf_b),
        .start       (start_b)
    );

    // Flag set is applied after the read-clear so a coincident underflow survives.
    always_comb begin
        flags_next = flags;
        if (rd_hit && addr == OFF_ICR) begin
            flags_next = '0;
        end
        flags_next = flags_next | {uf_b, uf_a};

        mask_next = mask;
        if (wr_hit && addr == OFF_ICR) begin
            mask_next = di[ICR_SET] ? (mask | di[1:0]) : (mask & ~di[1:0]);
        end
    end

    always_comb begin
        rd_mux = '0;
        case (addr)
            OFF_TALO: rd_mux = counter_a[DW-1:0];
            OFF_TAHI: rd_mux = counter_a[TW-1:DW];
            OFF_TBLO: rd_mux = counter_b[DW-1:0];
            OFF_TBHI: rd_mux = counter_b[TW-1:DW];
            OFF_ICR: begin
                rd_mux[ICR_IRQ] = !irq_n;
                rd_mux[ICR_TB]  = flags[1];
                rd_mux[ICR_TA]  = flags[0];
            end
            OFF_CRA:  rd_mux = cr_a;
            OFF_CRB:  rd_mux = cr_b;
            default:  rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags   <= '0;
            mask    <= '0;
            irq_n   <= 1'b1;
            rd_data <= '0;
        end else begin
            flags <= flags_next;
            mask  <= mask_next;
            irq_n <= !(|(flags_next & mask_next));
            if (rd_hit) begin
                rd_data <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_cia_timer.sv
// Directed bench for cia_timer: a per-cycle vector table for free-running
// counting plus hand sequences for one-shot, cascade, collisions and reset.
module tb_cia_timer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cs, we, tick;
    logic [3:0] addr;
    logic [7:0] di;
    logic [7:0] rd_data;
    logic       irq_n;

    int total = 0;
    int bad   = 0;

    cia_timer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .cs      (cs),
        .we      (we),
        .addr    (addr),
        .di      (di),
        .rd_data (rd_data),
        .tick    (tick),
        .irq_n   (irq_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       cs;
        logic       we;
        logic [3:0] a;
        logic [7:0] d;
        logic       tk;
        logic [7:0] exp_do;
        logic       exp_irq_n;
    } vec_t;

    vec_t vecs[16];

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h want %02h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b want %0b", name, act, exp);
        end
    endtask

    // All bus tasks start and end on a falling edge; outputs are sampled there.
    task automatic bus(input logic c, input logic w, input logic [3:0] a,
                       input logic [7:0] d, input logic tk);
        cs = c; we = w; addr = a; di = d; tick = tk;
        @(negedge clk);
        cs = 1'b0; we = 1'b0; tick = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        bus(1'b1, 1'b1, a, d, 1'b0);
    endtask

    task automatic rd_chk(input string name, input logic [3:0] a, input logic [7:0] exp);
        bus(1'b1, 1'b0, a, 8'h00, 1'b0);
        chk8(name, rd_data, exp);
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        repeat (n) @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        //            cs    we    a      d      tk    do     irq_n
        vecs[0]  = '{1'b1, 1'b1, 4'h4, 8'h03, 1'b0, 8'h00, 1'b1};
        vecs[1]  = '{1'b1, 1'b1, 4'h5, 8'h00, 1'b0, 8'h00, 1'b1};
        vecs[2]  = '{1'b1, 1'b1, 4'hD, 8'h81, 1'b0, 8'h00, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 4'hE, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 4'h4, 8'h00, 1'b1, 8'h03, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 4'h4, 8'h00, 1'b1, 8'h02, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 4'h4, 8'h00, 1'b1, 8'h01, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 4'h4, 8'h00, 1'b1, 8'h00, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 4'h4, 8'h00, 1'b1, 8'h03, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 4'h4, 8'h00, 1'b1, 8'h02, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 4'h4, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 4'hD, 8'h00, 1'b0, 8'h81, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 8'h81, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 4'h4, 8'h00, 1'b1, 8'h00, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 4'hD, 8'h00, 1'b1, 8'h81, 1'b1};
        vecs[15] = '{1'b1, 1'b1, 4'hE, 8'h00, 1'b0, 8'h81, 1'b1};

        reset_n = 1'b0; cs = 1'b0; we = 1'b0; tick = 1'b0; addr = 4'h0; di = 8'h00;
        repeat (2) @(negedge clk);
        chk8("reset_do", rd_data, 8'h00);
        chk1("reset_irq", irq_n, 1'b1);
        reset_n = 1'b1;
        @(negedge clk);

        rd_chk("reset_talo", 4'h4, 8'hFF);
        rd_chk("reset_tahi", 4'h5, 8'hFF);
        rd_chk("unmapped_rd", 4'h0, 8'h00);
        wr(4'h2, 8'h55);
        rd_chk("unmapped_wr", 4'h2, 8'h00);

        // Continuous count, one vector per clock.
        for (int i = 0; i < 16; i++) begin
            cs = vecs[i].cs; we = vecs[i].we; addr = vecs[i].a;
            di = vecs[i].d; tick = vecs[i].tk;
            @(negedge clk);
            chk8($sformatf("cont_do[%0d]", i), rd_data, vecs[i].exp_do);
            chk1($sformatf("cont_irq[%0d]", i), irq_n, vecs[i].exp_irq_n);
        end
        cs = 1'b0; we = 1'b0; tick = 1'b0;

        // One-shot: single underflow after 3 ticks, then stopped with counter at latch.
        do_reset();
        wr(4'h4, 8'h02);
        wr(4'h5, 8'h00);
        wr(4'hD, 8'h81);
        wr(4'hE, 8'h09);
        ticks(3);
        chk1("os_irq_low", irq_n, 1'b0);
        rd_chk("os_icr", 4'hD, 8'h81);
        chk1("os_irq_clr", irq_n, 1'b1);
        ticks(5);
        rd_chk("os_no_more", 4'hD, 8'h00);
        rd_chk("os_cra", 4'hE, 8'h08);
        rd_chk("os_cnt", 4'h4, 8'h02);

        // Cascade: B counts A underflows, only B unmasked.
        do_reset();
        wr(4'h4, 8'h01);
        wr(4'h5, 8'h00);
        wr(4'h6, 8'h02);
        wr(4'h7, 8'h00);
        wr(4'hD, 8'h82);
        wr(4'hF, 8'h41);
        wr(4'hE, 8'h01);
        ticks(5);
        chk1("casc_irq_5", irq_n, 1'b1);
        ticks(1);
        chk1("casc_irq_6", irq_n, 1'b0);
        rd_chk("casc_icr", 4'hD, 8'h83);
        chk1("casc_irq_clr", irq_n, 1'b1);
        ticks(5);
        chk1("casc_irq_11", irq_n, 1'b1);
        ticks(1);
        chk1("casc_irq_12", irq_n, 1'b0);

        // Reset mid-count, asynchronously, while do and irq_n are active.
        reset_n = 1'b0;
        #2;
        chk8("arst_do", rd_data, 8'h00);
        chk1("arst_irq", irq_n, 1'b1);
        reset_n = 1'b1;
        @(negedge clk);
        ticks(4);
        rd_chk("arst_talo", 4'h4, 8'hFF);
        rd_chk("arst_cra", 4'hE, 8'h00);
        rd_chk("arst_crb", 4'hF, 8'h00);

        // ICR read coincident with an A underflow.
        do_reset();
        wr(4'h4, 8'h03);
        wr(4'h5, 8'h00);
        wr(4'hD, 8'h81);
        wr(4'hE, 8'h01);
        ticks(3);
        chk1("coll_pre_irq", irq_n, 1'b1);
        bus(1'b1, 1'b0, 4'hD, 8'h00, 1'b1);
        chk8("coll_icr_rd", rd_data, 8'h00);
        chk1("coll_irq", irq_n, 1'b0);
        rd_chk("coll_icr_next", 4'hD, 8'h81);

        // LOAD strobe coincident with underflow, then with a plain decrement.
        ticks(3);
        bus(1'b1, 1'b1, 4'hE, 8'h11, 1'b1);
        rd_chk("load_vs_uf", 4'h4, 8'h03);
        ticks(1);
        bus(1'b1, 1'b1, 4'hE, 8'h11, 1'b1);
        rd_chk("load_vs_dec", 4'h4, 8'h03);
        rd_chk("load_cra", 4'hE, 8'h01);

        // High-latch write while running only affects the next reload.
        do_reset();
        wr(4'h4, 8'h03);
        wr(4'h5, 8'h00);
        wr(4'hE, 8'hE1);
        ticks(1);
        wr(4'h5, 8'h10);
        rd_chk("run_lo", 4'h4, 8'h02);
        rd_chk("run_hi", 4'h5, 8'h00);
        ticks(3);
        rd_chk("reload_hi", 4'h5, 8'h10);
        rd_chk("reload_lo", 4'h4, 8'h03);
        rd_chk("cra_upper", 4'hE, 8'hE1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
